pipeline_hazard_ctrl: RTL and testbench

//  Control block for the 3-stage F / DE / MW datapath.
//  - Decodes instruction2 and instruction3 and drives stall, stallMW, flush, bubble_mw, forward_A and forward_B.
//  - Inserts the wait cycles needed by a multi-cycle data memory.
//  - Sequences external interrupt requests into the CSR file's interrupt vector at a safe pipeline boundary.

---
 rtl/pipeline_hazard_ctrl_if.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bus between the F/DE/MW datapath (master) and the hazard/interrupt controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int IRQ_N = 4
);
  logic [31:0]      instruction2;
  logic [31:0]      instruction3;
  logic             reg_wrMW;
  logic             br_taken3;
  logic             epc_taken;
  logic [IRQ_N-1:0] irq_req;
  logic             stall;
  logic             stallMW;
  logic             flush;
  logic             bubble_mw;
  logic             forward_A;
  logic             forward_B;
  logic [31:0]      interrupt;
  logic             irq_err;

  modport master (
    output instruction2, instruction3, reg_wrMW, br_taken3, epc_taken, irq_req,
    input  stall, stallMW, flush, bubble_mw, forward_A, forward_B, interrupt, irq_err
  );

  modport slave (
    input  instruction2, instruction3, reg_wrMW, br_taken3, epc_taken, irq_req,
    output stall, stallMW, flush, bubble_mw, forward_A, forward_B, interrupt, irq_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, memory-wait and interrupt-injection control for the F/DE/MW pipeline.
// Optional IRQ_ROTATE_PRIORITY_EN selects round-robin instead of fixed interrupt priority.
module pipeline_hazard_ctrl #(
  parameter int MEM_LAT     = 1,
  parameter int IRQ_N       = 4,
  parameter int IRQ_TIMEOUT = 8
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam int TMR_W = $clog2(IRQ_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IRQ_TIMEOUT - 1);
  localparam int ID_W = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
`ifdef IRQ_ROTATE_PRIORITY_EN
  localparam logic [ID_W-1:0] ID_RESET = ID_W'(IRQ_N - 1);
`else
  localparam logic [ID_W-1:0] ID_RESET = '0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_INJECT, S_WAIT_EPC} irq_state_t;

  logic [6:0] op2, op3;
  logic [4:0] rs1, rs2, rd3;
  logic       use_rs1, use_rs2, haz_a, haz_b;
  logic       alu_prod, nonalu_prod, mem_op, load_use;
  logic       unused_bits;

  assign op2 = bus.instruction2[6:0];
  assign rs1 = bus.instruction2[19:15];
  assign rs2 = bus.instruction2[24:20];
  assign op3 = bus.instruction3[6:0];
  assign rd3 = bus.instruction3[11:7];
  assign unused_bits = ^{bus.instruction2[31:25], bus.instruction2[14:7], bus.instruction3[31:12]};

  always_comb begin
    use_rs1     = !((op2 == OP_LUI) || (op2 == OP_AUIPC) || (op2 == OP_JAL));
    use_rs2     = (op2 == OP_REG) || (op2 == OP_STORE) || (op2 == OP_BRANCH);
    haz_a       = bus.reg_wrMW && (rd3 != 5'd0) && use_rs1 && (rs1 == rd3);
    haz_b       = bus.reg_wrMW && (rd3 != 5'd0) && use_rs2 && (rs2 == rd3);
    alu_prod    = (op3 == OP_REG) || (op3 == OP_IMM) || (op3 == OP_LUI) || (op3 == OP_AUIPC);
    nonalu_prod = (op3 == OP_LOAD) || (op3 == OP_JAL) || (op3 == OP_JALR) || (op3 == OP_SYSTEM);
    mem_op      = (op3 == OP_LOAD) || (op3 == OP_STORE);
    load_use    = (haz_a || haz_b) && nonalu_prod;
  end

  // fresh_q marks a newly arrived MW instruction, so a held one never reloads the wait count.
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_rem;
  logic             fresh_q;
  logic             flush_i, stall_i, stall_mw_i, bubble_i;

  assign flush_i = bus.br_taken3 || bus.epc_taken;
  assign cnt_rem = (mem_op && fresh_q) ? CNT_LOAD : cnt_q;

  always_comb begin
    stall_i    = 1'b0;
    stall_mw_i = 1'b0;
    bubble_i   = 1'b0;
    cnt_d      = '0;
    if (flush_i) begin
      cnt_d = '0;
    end else if (cnt_rem != '0) begin
      stall_i    = 1'b1;
      stall_mw_i = 1'b1;
      cnt_d      = cnt_rem - CNT_W'(1);
    end else if (load_use) begin
      stall_i  = 1'b1;
      bubble_i = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      fresh_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      fresh_q <= !stall_mw_i;
    end
  end

  // id_q doubles as the last granted index for the round-robin search.
  irq_state_t       state_q, state_d;
  logic [IRQ_N-1:0] pending_q, pending_d, clr;
  logic [ID_W-1:0]  id_q, id_d, grant_id;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d, found, safe;

`ifdef IRQ_ROTATE_PRIORITY_EN
  int idx;
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    idx      = 0;
    for (int k = 0; k < IRQ_N; k++) begin
      idx = (int'(id_q) + 1 + k) % IRQ_N;
      if (!found && pending_q[idx]) begin
        found    = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
  end
`else
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int k = IRQ_N - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        found    = 1'b1;
        grant_id = ID_W'(k);
      end
    end
  end
`endif

  assign safe = !stall_i && !flush_i && (op3 != OP_SYSTEM);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    timer_d = timer_q;
    err_d   = err_q;
    clr     = '0;
    case (state_q)
      S_IDLE: begin
        if (pending_q != '0) state_d = S_PEND;
      end
      S_PEND: begin
        if (safe && found) begin
          state_d       = S_INJECT;
          id_d          = grant_id;
          clr[grant_id] = 1'b1;
        end
      end
      S_INJECT: begin
        state_d = S_WAIT_EPC;
        timer_d = '0;
      end
      S_WAIT_EPC: begin
        if (bus.epc_taken) begin
          state_d = S_IDLE;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    pending_d = (pending_q | bus.irq_req) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      id_q      <= ID_RESET;
      timer_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      id_q      <= id_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
    end
  end

  assign bus.stall     = stall_i && !reset;
  assign bus.stallMW   = stall_mw_i && !reset;
  assign bus.flush     = flush_i && !reset;
  assign bus.bubble_mw = bubble_i && !reset;
  assign bus.forward_A = haz_a && alu_prod && !reset;
  assign bus.forward_B = haz_b && alu_prod && !reset;
  assign bus.interrupt = ((state_q == S_INJECT) && !reset) ? (32'd1 << id_q) : 32'd0;
  assign bus.irq_err   = err_q && !reset;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (MEM_LAT=3, IRQ_N=4, IRQ_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

  localparam logic [31:0] NOP          = 32'h00000013;
  localparam logic [31:0] ADDI_X5_7    = 32'h00700293;
  localparam logic [31:0] ADD_X6_X5_X5 = 32'h00528333;
  localparam logic [31:0] ADDI_X6_X5   = 32'h00528313;
  localparam logic [31:0] LUI_X6       = 32'h00028337;
  localparam logic [31:0] ADDI_X0_7    = 32'h00700013;
  localparam logic [31:0] ADD_X6_X0_X0 = 32'h00000333;
  localparam logic [31:0] LW_X5        = 32'h0000A283;
  localparam logic [31:0] ADD_X6_X5_X0 = 32'h00028333;
  localparam logic [31:0] SW_X5        = 32'h0050A023;
  localparam logic [31:0] ECALL        = 32'h00000073;

  typedef struct {
    string       name;
    logic [38:0] val;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  exp_t cur;
  int   n_checks;
  int   n_fail;

  pipeline_hazard_ctrl_if #(.IRQ_N(4)) bus_if ();

  pipeline_hazard_ctrl #(.MEM_LAT(3), .IRQ_N(4), .IRQ_TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs {stall, stallMW, flush, bubble_mw, forward_A, forward_B, interrupt, irq_err}.
  function automatic logic [38:0] mk(input logic st, input logic sm, input logic fl, input logic bu,
                                     input logic fa, input logic fb, input logic [31:0] it, input logic er);
    return {st, sm, fl, bu, fa, fb, it, er};
  endfunction

  task automatic applyStimulus(input string name, input logic rst, input logic [31:0] i2,
                               input logic [31:0] i3, input logic wr, input logic br, input logic epc,
                               input logic [3:0] irq, input logic [38:0] exp_val);
    exp_t e;
    @(posedge clk);
    #1;
    reset               = rst;
    bus_if.instruction2 = i2;
    bus_if.instruction3 = i3;
    bus_if.reg_wrMW     = wr;
    bus_if.br_taken3    = br;
    bus_if.epc_taken    = epc;
    bus_if.irq_req      = irq;
    e.name = name;
    e.val  = exp_val;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [38:0] act;
    act = {bus_if.stall, bus_if.stallMW, bus_if.flush, bus_if.bubble_mw,
           bus_if.forward_A, bus_if.forward_B, bus_if.interrupt, bus_if.irq_err};
    n_checks++;
    if (act !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: got st/smw/fl/bub/fa/fb=%b%b%b%b%b%b int=%h err=%b, expected %b%b%b%b%b%b int=%h err=%b",
               e.name, act[38], act[37], act[36], act[35], act[34], act[33], act[32:1], act[0],
               e.val[38], e.val[37], e.val[36], e.val[35], e.val[34], e.val[33], e.val[32:1], e.val[0]);
    end
  endtask

  // Monitor: one response per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checkOutput(cur);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [38:0] z;
    z = '0;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus_if.instruction2 = NOP;
    bus_if.instruction3 = NOP;
    bus_if.reg_wrMW  = 1'b0;
    bus_if.br_taken3 = 1'b0;
    bus_if.epc_taken = 1'b0;
    bus_if.irq_req   = 4'h0;

    // Reset gates every output even with hazards, flush and requests present.
    applyStimulus("rst_fwd",   1, ADD_X6_X5_X5, ADDI_X5_7, 1, 0, 0, 4'hF, z);
    applyStimulus("rst_flush", 1, ADD_X6_X5_X5, ADDI_X5_7, 1, 1, 0, 4'h0, z);

    // Forwarding from ALU producers.
    applyStimulus("fwd_ab",     0, ADD_X6_X5_X5, ADDI_X5_7, 1, 0, 0, 4'h0, mk(0,0,0,0,1,1,0,0));
    applyStimulus("fwd_a_only", 0, ADDI_X6_X5,   ADDI_X5_7, 1, 0, 0, 4'h0, mk(0,0,0,0,1,0,0,0));
    applyStimulus("lui_no_rs1", 0, LUI_X6,       ADDI_X5_7, 1, 0, 0, 4'h0, z);
    applyStimulus("rd_x0",      0, ADD_X6_X0_X0, ADDI_X0_7, 1, 0, 0, 4'h0, z);
    applyStimulus("no_wr",      0, ADD_X6_X5_X5, ADDI_X5_7, 0, 0, 0, 4'h0, z);

    // Load: 2 memory-wait cycles, then 1 load-use bubble cycle.
    applyStimulus("lw_wait1", 0, ADD_X6_X5_X0, LW_X5, 1, 0, 0, 4'h0, mk(1,1,0,0,0,0,0,0));
    applyStimulus("lw_wait2", 0, ADD_X6_X5_X0, LW_X5, 1, 0, 0, 4'h0, mk(1,1,0,0,0,0,0,0));
    applyStimulus("lw_use",   0, ADD_X6_X5_X0, LW_X5, 1, 0, 0, 4'h0, mk(1,0,0,1,0,0,0,0));
    applyStimulus("lw_after", 0, ADD_X6_X5_X0, NOP,   0, 0, 0, 4'h0, z);

    // Store wait, back-to-back reload, reset and flush during the wait.
    applyStimulus("sw_wait1",  0, NOP, SW_X5, 0, 0, 0, 4'h0, mk(1,1,0,0,0,0,0,0));
    applyStimulus("sw_wait2",  0, NOP, SW_X5, 0, 0, 0, 4'h0, mk(1,1,0,0,0,0,0,0));
    applyStimulus("sw_rel",    0, NOP, SW_X5, 0, 0, 0, 4'h0, z);
    applyStimulus("sw2_wait1", 0, NOP, SW_X5, 0, 0, 0, 4'h0, mk(1,1,0,0,0,0,0,0));
    applyStimulus("sw2_wait2", 0, NOP, SW_X5, 0, 0, 0, 4'h0, mk(1,1,0,0,0,0,0,0));
    applyStimulus("sw2_rel",   0, NOP, SW_X5, 0, 0, 0, 4'h0, z);
    applyStimulus("sw3_wait1", 0, NOP, SW_X5, 0, 0, 0, 4'h0, mk(1,1,0,0,0,0,0,0));
    applyStimulus("sw3_rst",   1, NOP, SW_X5, 0, 0, 0, 4'h0, z);
    applyStimulus("sw3_after", 0, NOP, NOP,   0, 0, 0, 4'h0, z);
    applyStimulus("sw4_wait1", 0, NOP, SW_X5, 0, 0, 0, 4'h0, mk(1,1,0,0,0,0,0,0));
    applyStimulus("sw4_flush", 0, NOP, SW_X5, 0, 1, 0, 4'h0, mk(0,0,1,0,0,0,0,0));
    applyStimulus("sw4_after", 0, NOP, NOP,   0, 0, 0, 4'h0, z);

    // Flush overrides load-use and memory wait.
    applyStimulus("br_over_lu", 0, ADD_X6_X5_X0, LW_X5, 1, 1, 0, 4'h0, mk(0,0,1,0,0,0,0,0));
    applyStimulus("br_after",   0, NOP,          NOP,   0, 0, 0, 4'h0, z);
    applyStimulus("epc_flush",  0, NOP,          SW_X5, 0, 0, 1, 4'h0, mk(0,0,1,0,0,0,0,0));
    applyStimulus("epc_after",  0, NOP,          NOP,   0, 0, 0, 4'h0, z);

    // Two simultaneous requests: index 1 first, then index 2.
    applyStimulus("irq_req",    0, NOP, NOP, 0, 0, 0, 4'b0110, z);
    applyStimulus("irq_idle",   0, NOP, NOP, 0, 0, 0, 4'h0, z);
    applyStimulus("irq_pend",   0, NOP, NOP, 0, 0, 0, 4'h0, z);
    applyStimulus("irq_inj1",   0, NOP, NOP, 0, 0, 0, 4'h0, mk(0,0,0,0,0,0,32'h2,0));
    applyStimulus("irq_wait1",  0, NOP, NOP, 0, 0, 0, 4'h0, z);
    applyStimulus("irq_epc1",   0, NOP, NOP, 0, 0, 1, 4'h0, mk(0,0,1,0,0,0,0,0));
    applyStimulus("irq_idle2",  0, NOP, NOP, 0, 0, 0, 4'h0, z);
    applyStimulus("irq_pend2",  0, NOP, NOP, 0, 0, 0, 4'h0, z);
    applyStimulus("irq_inj2",   0, NOP, NOP, 0, 0, 0, 4'h0, mk(0,0,0,0,0,0,32'h4,0));
    applyStimulus("irq_epc2",   0, NOP, NOP, 0, 0, 1, 4'h0, mk(0,0,1,0,0,0,0,0));
    applyStimulus("irq_quiet",  0, NOP, NOP, 0, 0, 0, 4'h0, z);

    // SYSTEM in MW delays injection; no acknowledge leads to the timeout error.
    applyStimulus("to_req",   0, NOP, NOP,   0, 0, 0, 4'b0001, z);
    applyStimulus("to_idle",  0, NOP, NOP,   0, 0, 0, 4'h0, z);
    applyStimulus("to_sys",   0, NOP, ECALL, 0, 0, 0, 4'h0, z);
    applyStimulus("to_pend",  0, NOP, NOP,   0, 0, 0, 4'h0, z);
    applyStimulus("to_inj",   0, NOP, NOP,   0, 0, 0, 4'h0, mk(0,0,0,0,0,0,32'h1,0));
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("to_wait%0d", i), 0, NOP, NOP, 0, 0, 0, 4'h0, z);
    end
    applyStimulus("to_err",    0, NOP, NOP, 0, 0, 0, 4'h0, mk(0,0,0,0,0,0,0,1));
    applyStimulus("to_sticky", 0, NOP, NOP, 0, 1, 0, 4'h0, mk(0,0,1,0,0,0,0,1));

    // Reset while waiting for acknowledge clears everything, including irq_err.
    applyStimulus("rw_req",   0, NOP, NOP, 0, 0, 0, 4'b1000, mk(0,0,0,0,0,0,0,1));
    applyStimulus("rw_idle",  0, NOP, NOP, 0, 0, 0, 4'h0, mk(0,0,0,0,0,0,0,1));
    applyStimulus("rw_pend",  0, NOP, NOP, 0, 0, 0, 4'h0, mk(0,0,0,0,0,0,0,1));
    applyStimulus("rw_inj",   0, NOP, NOP, 0, 0, 0, 4'h0, mk(0,0,0,0,0,0,32'h8,1));
    applyStimulus("rw_wait",  0, NOP, NOP, 0, 0, 0, 4'h0, mk(0,0,0,0,0,0,0,1));
    applyStimulus("rw_rst",   1, NOP, NOP, 0, 0, 0, 4'h0, z);
    applyStimulus("rw_post1", 0, NOP, NOP, 0, 0, 0, 4'h0, z);
    applyStimulus("rw_post2", 0, NOP, NOP, 0, 0, 0, 4'h0, z);
    applyStimulus("rw_post3", 0, NOP, NOP, 0, 0, 0, 4'h0, z);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
